// File: rtl/alu_issue_if.sv
// Bundle of command, ALU operand/result and result-handshake signals for the
// ALU issue unit. The unit uses the slave view; the command producer, ALU and
// result consumer together use the master view.
interface alu_issue_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       cmd_use_acc;

    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_sel;
    logic [7:0] alu_out;
    logic       alu_zero;

    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_zero;
    logic [7:0] acc;
    logic       busy;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc,
        input  alu_out, alu_zero, res_ready,
        output cmd_ready, alu_a, alu_b, alu_sel,
        output res_valid, res_data, res_zero, acc, busy
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc,
        output alu_out, alu_zero, res_ready,
        input  cmd_ready, alu_a, alu_b, alu_sel,
        input  res_valid, res_data, res_zero, acc, busy
    );
endinterface

// File: rtl/alu_issue_unit.sv
// Issue stage for an 8-bit combinational ALU: buffers commands in a FIFO,
// issues one at a time into registered ALU inputs, captures result and Zero
// flag (also into the accumulator) and offers the result on a valid/ready port.
module alu_issue_unit #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    alu_issue_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state_q, state_d;

    // Command storage (payload only; validity is tracked by count_q)
    logic [2:0]      op_mem [DEPTH];
    logic [7:0]      a_mem  [DEPTH];
    logic [7:0]      b_mem  [DEPTH];
    logic            ua_mem [DEPTH];

    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;

    logic [7:0]      alu_a_q, alu_b_q;
    logic [2:0]      alu_sel_q;
    logic [7:0]      res_data_q, acc_q;
    logic            res_zero_q, res_valid_q;

    logic            fifo_empty;
    logic            push, pop, capture, release_res;

    assign fifo_empty    = (count_q == '0);
    assign bus.cmd_ready = (count_q < DEPTH_C);
    assign push          = bus.cmd_valid && bus.cmd_ready;

    // Next-state and per-cycle control decode for the issue sequencer
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                capture = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (bus.res_ready) begin
                    release_res = 1'b1;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FIFO payload write; stale entries are harmless since count_q gates reads
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr_q] <= bus.cmd_op;
            a_mem[wr_ptr_q]  <= bus.cmd_a;
            b_mem[wr_ptr_q]  <= bus.cmd_b;
            ua_mem[wr_ptr_q] <= bus.cmd_use_acc;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Issue: load ALU inputs from the FIFO head; operand A may come from acc
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= '0;
        end else if (pop) begin
            alu_sel_q <= op_mem[rd_ptr_q];
            alu_b_q   <= b_mem[rd_ptr_q];
            alu_a_q   <= ua_mem[rd_ptr_q] ? acc_q : a_mem[rd_ptr_q];
        end
    end

    // Capture ALU output after its settle cycle; hold until consumer accepts
    always_ff @(posedge clk) begin
        if (rst) begin
            res_data_q  <= '0;
            res_zero_q  <= 1'b0;
            acc_q       <= '0;
            res_valid_q <= 1'b0;
        end else if (capture) begin
            res_data_q  <= bus.alu_out;
            res_zero_q  <= bus.alu_zero;
            acc_q       <= bus.alu_out;
            res_valid_q <= 1'b1;
        end else if (release_res) begin
            res_valid_q <= 1'b0;
        end
    end

    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_sel   = alu_sel_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_zero  = res_zero_q;
    assign bus.acc       = acc_q;
    assign bus.busy      = (state_q != IDLE) || !fifo_empty;
endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed and random-reference bench for alu_issue_unit with a behavioural
// 8-bit ALU attached to the ALU operand/result signals.
module tb_alu_issue_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_issue_if bus ();

    alu_issue_unit #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: returns {zero, result}
    function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        case (op)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            3'd5:    r = a << 1;
            3'd6:    r = a >> 1;
            default: r = ~a;
        endcase
        return {(r == 8'h00), r};
    endfunction

    logic [8:0] alu_res;
    assign alu_res      = alu_f(bus.alu_sel, bus.alu_a, bus.alu_b);
    assign bus.alu_out  = alu_res[7:0];
    assign bus.alu_zero = alu_res[8];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic ua);
        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = op;
        bus.cmd_a       = a;
        bus.cmd_b       = b;
        bus.cmd_use_acc = ua;
        chk("send_ready", 32'(bus.cmd_ready), 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [7:0] exp_d, input logic exp_z);
        int n;
        n = 0;
        bus.res_ready = 1'b1;
        while (!bus.res_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_vld"}, 32'(bus.res_valid), 32'd1);
        chk({tag, "_data"}, 32'(bus.res_data), 32'(exp_d));
        chk({tag, "_zero"}, 32'(bus.res_zero), 32'(exp_z));
        tick();
        bus.res_ready = 1'b0;
    endtask

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int         accepted;
    int         sent, got, cyc;
    logic       v, ua, stale;
    logic [2:0] rop;
    logic [7:0] ra, rb, macc;
    logic [8:0] r, e;
    logic [8:0] expq [$];

    initial begin
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = '0;
        bus.cmd_a       = '0;
        bus.cmd_b       = '0;
        bus.cmd_use_acc = 1'b0;
        bus.res_ready   = 1'b0;

        // Reset state
        do_reset();
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_res_data",  32'(bus.res_data),  32'd0);
        chk("rst_res_zero",  32'(bus.res_zero),  32'd0);
        chk("rst_acc",       32'(bus.acc),       32'd0);
        chk("rst_alu_a",     32'(bus.alu_a),     32'd0);
        chk("rst_alu_sel",   32'(bus.alu_sel),   32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Single ADD with exact latency: accepted at k, issued k+1, valid k+2
        bus.cmd_valid = 1'b1; bus.cmd_op = 3'd0; bus.cmd_a = 8'hF0; bus.cmd_b = 8'h20; bus.cmd_use_acc = 1'b0;
        tick();
        bus.cmd_valid = 1'b0;
        chk("t1_k_vld", 32'(bus.res_valid), 32'd0);
        tick();
        chk("t1_k1_vld",   32'(bus.res_valid), 32'd0);
        chk("t1_k1_alu_a", 32'(bus.alu_a),     32'hF0);
        chk("t1_k1_alu_b", 32'(bus.alu_b),     32'h20);
        chk("t1_k1_sel",   32'(bus.alu_sel),   32'd0);
        tick();
        chk("t1_k2_vld",  32'(bus.res_valid), 32'd1);
        chk("t1_k2_data", 32'(bus.res_data),  32'h10);
        chk("t1_k2_zero", 32'(bus.res_zero),  32'd0);
        chk("t1_k2_acc",  32'(bus.acc),       32'h10);
        tick();
        chk("t1_hold_vld",  32'(bus.res_valid), 32'd1);
        chk("t1_hold_data", 32'(bus.res_data),  32'h10);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk("t1_done_vld",  32'(bus.res_valid), 32'd0);
        chk("t1_done_busy", 32'(bus.busy),      32'd0);
        chk("t1_alu_a_kept", 32'(bus.alu_a),    32'hF0);

        // SUB to zero
        send(3'd1, 8'h05, 8'h05, 1'b0);
        wait_result("t2", 8'h00, 1'b1);

        // Accumulator chain: 3+4=7, acc+1=8, acc>>1=4
        send(3'd0, 8'h03, 8'h04, 1'b0);
        send(3'd0, 8'h55, 8'h01, 1'b1);
        send(3'd6, 8'hAA, 8'h33, 1'b1);
        wait_result("chain0", 8'h07, 1'b0);
        wait_result("chain1", 8'h08, 1'b0);
        wait_result("chain2", 8'h04, 1'b0);
        chk("chain_acc", 32'(bus.acc), 32'h04);

        // Backpressure: res_ready low, command offered every cycle
        do_reset();
        accepted = 0;
        for (int i = 0; i < 10; i++) begin
            bus.cmd_valid = 1'b1; bus.cmd_op = 3'd0; bus.cmd_a = 8'(accepted);
            bus.cmd_b = 8'h10; bus.cmd_use_acc = 1'b0;
            if (bus.cmd_ready) accepted++;
            tick();
        end
        bus.cmd_valid = 1'b0;
        chk("bp_accepted",  32'(accepted),      32'd5);
        chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("bp_vld",       32'(bus.res_valid), 32'd1);
        chk("bp_data_held", 32'(bus.res_data),  32'h10);
        bus.res_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_drain_vld", 32'(bus.res_valid), 32'((i % 2) == 0));
            if ((i % 2) == 0) chk("bp_drain_data", 32'(bus.res_data), 32'(8'h10 + 8'(i / 2)));
            tick();
        end
        bus.res_ready = 1'b0;
        chk("bp_busy_end", 32'(bus.busy), 32'd0);

        // Simultaneous push and pop at count = DEPTH-1
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.cmd_valid = 1'b1; bus.cmd_op = 3'd0; bus.cmd_a = 8'(8'h20 + i);
            bus.cmd_b = 8'h01; bus.cmd_use_acc = 1'b0;
            tick();
        end
        chk("pp_pre_count", 32'(dut.count_q), 32'd3);
        bus.cmd_a = 8'h24;
        bus.res_ready = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b0;
        chk("pp_count", 32'(dut.count_q), 32'd3);
        chk("pp_alu_a", 32'(bus.alu_a),   32'h21);
        wait_result("pp1", 8'h22, 1'b0);
        wait_result("pp2", 8'h23, 1'b0);
        wait_result("pp3", 8'h24, 1'b0);
        wait_result("pp4", 8'h25, 1'b0);
        chk("pp_busy", 32'(bus.busy), 32'd0);

        // Reset while EXEC with three commands buffered
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.cmd_valid = 1'b1; bus.cmd_op = 3'd0; bus.cmd_a = 8'(8'h40 + i);
            bus.cmd_b = 8'h00; bus.cmd_use_acc = 1'b0;
            tick();
        end
        bus.cmd_a = 8'h44;
        bus.res_ready = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b0;
        chk("rx_pre_count", 32'(dut.count_q), 32'd3);
        chk("rx_pre_acc",   32'(bus.acc),     32'h40);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rx_vld",       32'(bus.res_valid), 32'd0);
        chk("rx_acc",       32'(bus.acc),       32'd0);
        chk("rx_busy",      32'(bus.busy),      32'd0);
        chk("rx_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rx_res_data",  32'(bus.res_data),  32'd0);
        bus.res_ready = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.res_valid) stale = 1'b1;
        end
        bus.res_ready = 1'b0;
        chk("rx_no_stale", 32'(stale), 32'd0);

        // Random commands and random backpressure against a reference queue
        do_reset();
        sent = 0; got = 0; cyc = 0; macc = 8'h00;
        while ((sent < 200 || expq.size() != 0) && cyc < 5000) begin
            v   = (sent < 200) && ($urandom_range(0, 3) != 0);
            rop = 3'($urandom_range(0, 7));
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            ua  = 1'($urandom_range(0, 1));
            bus.cmd_valid   = v;
            bus.cmd_op      = rop;
            bus.cmd_a       = ra;
            bus.cmd_b       = rb;
            bus.cmd_use_acc = ua;
            bus.res_ready   = 1'($urandom_range(0, 1));
            if (v && bus.cmd_ready) begin
                r = alu_f(rop, ua ? macc : ra, rb);
                macc = r[7:0];
                expq.push_back(r);
                sent++;
            end
            if (bus.res_valid && bus.res_ready) begin
                chk("rnd_expected_pending", 32'(expq.size() != 0), 32'd1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    chk("rnd_result", 32'({bus.res_zero, bus.res_data}), 32'(e));
                    got++;
                end
            end
            tick();
            cyc++;
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b0;
        chk("rnd_sent", 32'(sent), 32'd200);
        chk("rnd_got",  32'(got),  32'd200);
        chk("rnd_busy", 32'(bus.busy), 32'd0);
        chk("rnd_acc",  32'(bus.acc),  32'(macc));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Upstream issue stage for the 8-bit combinational ALU (ops ADD/SUB/AND/OR/XOR/SHL/SHR/NOT; 3-bit select; Zero flag).
- Buffers operation commands in a small FIFO and drives the ALU operand/select inputs from registers.
- Captures the ALU result and Zero flag into an 8-bit accumulator and a result register.
- Presents results downstream with a valid/ready handshake.

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, >=2)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept; equals (count < DEPTH)
- cmd_op  in  3  ALU select code
- cmd_a  in  8  immediate operand A
- cmd_b  in  8  operand B
- cmd_use_acc  in  1  1: operand A = accumulator at issue time; 0: cmd_a
- alu_a  out  8  registered ALU operand A
- alu_b  out  8  registered ALU operand B
- alu_sel  out  3  registered ALU select
- alu_out  in  8  ALU result (combinational from alu_a/alu_b/alu_sel)
- alu_zero  in  1  ALU Zero flag
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  8  captured result
- res_zero  out  1  captured Zero flag
- acc  out  8  accumulator value
- busy  out  1  high when state != IDLE or FIFO non-empty

Behaviour:
- Reset:
  - Synchronous, active-high; takes priority over all other events, including mid-operation.
  - FIFO flushed (count=0, pointers 0); state=IDLE.
  - alu_a, alu_b, alu_sel, res_data, acc = 0; res_zero, res_valid = 0.
  - Any in-flight or buffered command is discarded.
- Push: on an edge with cmd_valid && cmd_ready, write {op, a, b, use_acc} at the write pointer.
- Simultaneous push and pop: count unchanged.
- No same-cycle bypass: a command written at edge k is poppable at edge k+1 at the earliest.
- Pointers wrap modulo DEPTH.
- States:
  - IDLE:
    - If FIFO non-empty, pop the head and load alu_sel=op, alu_b=b, alu_a=(use_acc ? acc : a); go EXEC.
    - Otherwise stay.
  - EXEC (one cycle; ALU settles):
    - At the edge: res_data<=alu_out, res_zero<=alu_zero, acc<=alu_out, res_valid<=1; go HOLD.
  - HOLD:
    - res_valid=1; res_data and res_zero are held stable while res_ready=0.
    - On an edge with res_ready=1: res_valid<=0; if FIFO non-empty, pop and load the ALU inputs as in IDLE and go EXEC, else go IDLE.
- Latency and throughput:
  - Command accepted at edge k into an empty, idle unit: popped at k+1, captured at k+2, so res_valid is high from k+2.
  - Peak throughput with res_ready=1 is one result per 2 cycles.
- Operand A when cmd_use_acc=1 is the accumulator value after all previously issued commands have completed; issue is strictly in order, one op in flight.
- Arithmetic: all results are 8-bit, wrap-around, taken exactly from alu_out; no carry captured. Zero is taken from alu_zero, not recomputed.
- alu_a, alu_b and alu_sel keep their last issued values when no new command is issued.
- Full FIFO: cmd_ready=0; cmd_valid is ignored and no overwrite occurs.
- Empty FIFO in IDLE: no ALU input change.

Test Plan:
- Reset then push {op=000, a=0xF0, b=0x20, use_acc=0} -> res_valid 2 cycles after acceptance; res_data=0x10, res_zero=0, acc=0x10.
- Push {001, 0x05, 0x05, 0} -> res_data=0x00, res_zero=1.
- Accumulator chain: {000, 3, 4, 0} then {000, x, 1, 1} then {110, x, x, 1} -> results 0x07, 0x08, 0x04 in order; acc=0x04.
- Backpressure:
  - Hold res_ready=0 and drive cmd_valid every cycle from reset.
  - Exactly 5 commands are accepted (1 in flight + DEPTH buffered), then cmd_ready=0; res_data stays stable.
  - Release res_ready: remaining 4 results drain in order at 1 per 2 cycles, then busy=0.
- Simultaneous push and pop at count=DEPTH-1: count unchanged, no data lost or duplicated; verify the output sequence against a reference model over 200 random commands with random res_ready.
- Assert rst in EXEC with 3 commands buffered -> next cycle: res_valid=0, acc=0, busy=0, cmd_ready=1; no stale result is ever presented.
